// File: rtl/enemy_fleet.sv
// Marching ROWS x COLS enemy block: alive mask, frame-paced movement,
// per-frame bullet scan (one ship per cycle) and a registered pixel stream.
module enemy_fleet #(
  parameter int          ROWS        = 3,
  parameter int          COLS        = 8,
  parameter int          SHIP_W      = 16,
  parameter int          SHIP_H      = 12,
  parameter int          PX_LG       = 5,
  parameter int          PY_LG       = 5,
  parameter int          START_LEFT  = 64,
  parameter int          START_TOP   = 40,
  parameter int          STEP_X      = 4,
  parameter int          STEP_Y      = 16,
  parameter int          MOVE_DIV    = 8,
  parameter int          LEFT_BOUND  = 8,
  parameter int          RIGHT_BOUND = 632,
  parameter int          LAND_Y      = 389,
  parameter logic [11:0] COLOR       = 12'hF0F,
  localparam int         N   = ROWS * COLS,
  localparam int         IW  = (N > 1) ? $clog2(N) : 1,
  localparam int         CW  = $clog2(N + 1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          frame_i,
  input  logic          start_i,
  input  logic [9:0]    x_i,
  input  logic [9:0]    y_i,
  input  logic          bullet_valid_i,
  input  logic [9:0]    bullet_left_i,
  input  logic [9:0]    bullet_right_i,
  input  logic [9:0]    bullet_top_i,
  input  logic [9:0]    bullet_bot_i,
  output logic          pixel_o,
  output logic [3:0]    red_o,
  output logic [3:0]    green_o,
  output logic [3:0]    blue_o,
  output logic          hit_o,
  output logic [IW-1:0] hit_idx_o,
  output logic [CW-1:0] alive_count_o,
  output logic [9:0]    fleet_left_o,
  output logic [9:0]    fleet_top_o,
  output logic          landed_o,
  output logic          cleared_o,
  output logic          busy_o
);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int FW  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT, S_SCAN, S_MOVE, S_LANDED, S_CLEARED
  } state_t;

  state_t state_q, state_d;

  logic [N-1:0]   alive_q;
  logic [CW-1:0]  count_q;
  logic [9:0]     left_q, top_q;
  logic           dir_left_q;
  logic [FW-1:0]  fcnt_q;
  logic [IW-1:0]  idx_q;
  logic [RW-1:0]  row_q, max_row_q;
  logic [CLW-1:0] col_q, min_col_q, max_col_q;
  logic [9:0]     bl_q, br_q, bt_q, bb_q;
  logic           bv_q, hit_done_q;

  logic [9:0] s_left, s_top;
  logic       scan_hit, last;
  logic [9:0] live_left, live_right;
  logic [9:0] left_d, top_d;
  logic       dir_d, step, land;
  logic [9:0] dx, dy, pcol, prow;
  logic [IW-1:0] pix_idx;
  logic       in_box, pix_on;

  always_comb begin
    s_left   = left_q + (10'(col_q) << PX_LG);
    s_top    = top_q + (10'(row_q) << PY_LG);
    scan_hit = alive_q[idx_q] && bv_q && !hit_done_q
            && bl_q < s_left + 10'(SHIP_W) && br_q > s_left
            && bt_q < s_top + 10'(SHIP_H) && bb_q > s_top;
    last     = idx_q == IW'(N - 1);
  end

  // Bounds use the live extent, so dead edge columns let the block travel further.
  always_comb begin
    live_left  = left_q + (10'(min_col_q) << PX_LG);
    live_right = left_q + (10'(max_col_q) << PX_LG) + 10'(SHIP_W);
    step       = fcnt_q == FW'(MOVE_DIV - 1);
    left_d     = left_q;
    top_d      = top_q;
    dir_d      = dir_left_q;
    if (step) begin
      if (!dir_left_q) begin
        if (live_right + 10'(STEP_X) > 10'(RIGHT_BOUND)) begin
          top_d = top_q + 10'(STEP_Y);
          dir_d = 1'b1;
        end else begin
          left_d = left_q + 10'(STEP_X);
        end
      end else begin
        if (live_left < 10'(LEFT_BOUND + STEP_X)) begin
          top_d = top_q + 10'(STEP_Y);
          dir_d = 1'b0;
        end else begin
          left_d = left_q - 10'(STEP_X);
        end
      end
    end
    land = top_d + (10'(max_row_q) << PY_LG) + 10'(SHIP_H) >= 10'(LAND_Y);
  end

  always_comb begin
    dx      = x_i - left_q;
    dy      = y_i - top_q;
    pcol    = dx >> PX_LG;
    prow    = dy >> PY_LG;
    pix_idx = IW'(32'(prow) * COLS + 32'(pcol));
    in_box  = x_i >= left_q && y_i >= top_q
           && pcol < 10'(COLS) && prow < 10'(ROWS)
           && 11'(dx[PX_LG-1:0]) < 11'(SHIP_W)
           && 11'(dy[PY_LG-1:0]) < 11'(SHIP_H);
    pix_on  = in_box && alive_q[pix_idx];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (start_i) state_d = S_WAIT;
      S_WAIT:    if (frame_i) state_d = S_SCAN;
      S_SCAN:    if (last) state_d = S_MOVE;
      S_MOVE: begin
        if (count_q == '0) state_d = S_CLEARED;
        else if (land)     state_d = S_LANDED;
        else               state_d = S_WAIT;
      end
      S_LANDED,
      S_CLEARED: if (start_i) state_d = S_WAIT;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      alive_q    <= '1;
      count_q    <= CW'(N);
      left_q     <= 10'(START_LEFT);
      top_q      <= 10'(START_TOP);
      dir_left_q <= 1'b0;
      fcnt_q     <= '0;
      idx_q      <= '0;
      row_q      <= '0;
      col_q      <= '0;
      min_col_q  <= '0;
      max_col_q  <= '0;
      max_row_q  <= '0;
      bl_q       <= '0;
      br_q       <= '0;
      bt_q       <= '0;
      bb_q       <= '0;
      bv_q       <= 1'b0;
      hit_done_q <= 1'b0;
      hit_o      <= 1'b0;
      hit_idx_o  <= '0;
      pixel_o    <= 1'b0;
    end else begin
      hit_o   <= 1'b0;
      pixel_o <= pix_on;
      if (state_q == S_WAIT && frame_i) begin
        bl_q       <= bullet_left_i;
        br_q       <= bullet_right_i;
        bt_q       <= bullet_top_i;
        bb_q       <= bullet_bot_i;
        bv_q       <= bullet_valid_i;
        idx_q      <= '0;
        row_q      <= '0;
        col_q      <= '0;
        hit_done_q <= 1'b0;
        min_col_q  <= CLW'(COLS - 1);
        max_col_q  <= '0;
        max_row_q  <= '0;
      end else if (state_q == S_SCAN) begin
        if (scan_hit) begin
          alive_q[idx_q] <= 1'b0;
          count_q        <= count_q - CW'(1);
          hit_o          <= 1'b1;
          hit_idx_o      <= idx_q;
          hit_done_q     <= 1'b1;
        end else if (alive_q[idx_q]) begin
          if (col_q < min_col_q) min_col_q <= col_q;
          if (col_q > max_col_q) max_col_q <= col_q;
          if (row_q > max_row_q) max_row_q <= row_q;
        end
        idx_q <= idx_q + IW'(1);
        if (col_q == CLW'(COLS - 1)) begin
          col_q <= '0;
          row_q <= row_q + RW'(1);
        end else begin
          col_q <= col_q + CLW'(1);
        end
      end else if (state_q == S_MOVE) begin
        fcnt_q     <= step ? '0 : fcnt_q + FW'(1);
        left_q     <= left_d;
        top_q      <= top_d;
        dir_left_q <= dir_d;
      end else if ((state_q == S_LANDED || state_q == S_CLEARED) && start_i) begin
        alive_q    <= '1;
        count_q    <= CW'(N);
        left_q     <= 10'(START_LEFT);
        top_q      <= 10'(START_TOP);
        dir_left_q <= 1'b0;
        fcnt_q     <= '0;
      end
    end
  end

  assign red_o         = pixel_o ? COLOR[11:8] : 4'h0;
  assign green_o       = pixel_o ? COLOR[7:4] : 4'h0;
  assign blue_o        = pixel_o ? COLOR[3:0] : 4'h0;
  assign alive_count_o = count_q;
  assign fleet_left_o  = left_q;
  assign fleet_top_o   = top_q;
  assign landed_o      = state_q == S_LANDED;
  assign cleared_o     = state_q == S_CLEARED;
  assign busy_o        = state_q == S_SCAN || state_q == S_MOVE;

endmodule

// File: tb/tb_enemy_fleet.sv
// Randomised and directed bench for enemy_fleet against a ship-list
// reference model (per-ship boxes, brute-force overlap and pixel search).
module tb_enemy_fleet;
  localparam int ROWS = 3;
  localparam int COLS = 8;
  localparam int N = ROWS * COLS;
  localparam int MOVE_DIV = 1;
  localparam int SW = 16;
  localparam int SH = 12;
  localparam int ST_IDLE = 0;
  localparam int ST_WAIT = 1;
  localparam int ST_LAND = 2;
  localparam int ST_CLR = 3;

  logic       clk = 0;
  logic       reset = 1;
  logic       frame = 0;
  logic       start = 0;
  logic [9:0] x = 0;
  logic [9:0] y = 0;
  logic       bv = 0;
  logic [9:0] bl = 0;
  logic [9:0] br = 0;
  logic [9:0] bt = 0;
  logic [9:0] bb = 0;
  logic       pixel;
  logic [3:0] red, green, blue;
  logic       hit;
  logic [4:0] hit_idx;
  logic [4:0] alive_count;
  logic [9:0] fleet_left, fleet_top;
  logic       landed, cleared, busy;

  enemy_fleet #(.MOVE_DIV(MOVE_DIV)) dut (
    .clk_i(clk), .reset_i(reset), .frame_i(frame), .start_i(start),
    .x_i(x), .y_i(y), .bullet_valid_i(bv),
    .bullet_left_i(bl), .bullet_right_i(br),
    .bullet_top_i(bt), .bullet_bot_i(bb),
    .pixel_o(pixel), .red_o(red), .green_o(green), .blue_o(blue),
    .hit_o(hit), .hit_idx_o(hit_idx), .alive_count_o(alive_count),
    .fleet_left_o(fleet_left), .fleet_top_o(fleet_top),
    .landed_o(landed), .cleared_o(cleared), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  bit m_alive[N];
  int m_left, m_top, m_dir, m_fcnt, m_st;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  function automatic int sl(int k);
    return (m_left + (k % COLS) * 32) & 1023;
  endfunction

  function automatic int stp(int k);
    return (m_top + (k / COLS) * 32) & 1023;
  endfunction

  function automatic int m_count();
    int n = 0;
    for (int k = 0; k < N; k++) n += int'(m_alive[k]);
    return n;
  endfunction

  function automatic int model_pix(int px, int py);
    for (int k = 0; k < N; k++)
      if (m_alive[k] && px >= sl(k) && px < sl(k) + SW &&
          py >= stp(k) && py < stp(k) + SH) return 1;
    return 0;
  endfunction

  task automatic model_reload();
    for (int k = 0; k < N; k++) m_alive[k] = 1;
    m_left = 64;
    m_top = 40;
    m_dir = 1;
    m_fcnt = 0;
  endtask

  task automatic model_frame(input bit v, input int l, input int r,
                             input int t, input int b, output int hk);
    int mnc, mxc, mxr, ll, lr;
    hk = -1;
    if (v)
      for (int k = 0; k < N; k++)
        if (hk < 0 && m_alive[k] && l < sl(k) + SW && r > sl(k) &&
            t < stp(k) + SH && b > stp(k)) hk = k;
    if (hk >= 0) m_alive[hk] = 0;
    mnc = COLS - 1;
    mxc = 0;
    mxr = 0;
    for (int k = 0; k < N; k++)
      if (m_alive[k]) begin
        if (k % COLS < mnc) mnc = k % COLS;
        if (k % COLS > mxc) mxc = k % COLS;
        if (k / COLS > mxr) mxr = k / COLS;
      end
    if (m_fcnt == MOVE_DIV - 1) begin
      m_fcnt = 0;
      ll = m_left + mnc * 32;
      lr = m_left + mxc * 32 + SW;
      if (m_dir > 0) begin
        if (lr + 4 > 632) begin m_top += 16; m_dir = -1; end
        else m_left += 4;
      end else begin
        if (ll < 12) begin m_top += 16; m_dir = 1; end
        else m_left -= 4;
      end
    end else m_fcnt++;
    if (m_count() == 0) m_st = ST_CLR;
    else if (m_top + mxr * 32 + SH >= 389) m_st = ST_LAND;
    else m_st = ST_WAIT;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst();
    check("rst_pixel", pixel, 0);
    check("rst_red", {red, green, blue}, 0);
    check("rst_hit", hit, 0);
    check("rst_hit_idx", hit_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_landed", landed, 0);
    check("rst_cleared", cleared, 0);
    check("rst_count", alive_count, 24);
    check("rst_left", fleet_left, 64);
    check("rst_top", fleet_top, 40);
  endtask

  task automatic do_reset();
    reset = 1;
    frame = 0;
    start = 0;
    x = 0;
    y = 0;
    tick();
    tick();
    check_rst();
    reset = 0;
    model_reload();
    m_st = ST_IDLE;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
    if (m_st == ST_IDLE) m_st = ST_WAIT;
    else if (m_st == ST_LAND || m_st == ST_CLR) begin
      model_reload();
      m_st = ST_WAIT;
    end
    check("start_count", alive_count, m_count());
    check("start_left", fleet_left, m_left);
    check("start_top", fleet_top, m_top);
    check("start_landed", landed, 0);
    check("start_cleared", cleared, 0);
  endtask

  task automatic pix(input int px, input int py);
    int e;
    x = 10'(px);
    y = 10'(py);
    tick();
    e = model_pix(px & 1023, py & 1023);
    check("pixel", pixel, e);
    check("colour", {red, green, blue}, e ? 12'hF0F : 12'h000);
  endtask

  task automatic fire(input bit v, input int l, input int r,
                      input int t, input int b);
    int hk, pulses, lastidx, nb, ol, ot;
    bv = v;
    bl = 10'(l);
    br = 10'(r);
    bt = 10'(t);
    bb = 10'(b);
    if (m_st != ST_WAIT) begin
      ol = m_left;
      ot = m_top;
      frame = 1;
      tick();
      frame = 0;
      nb = 0;
      repeat (3) begin
        tick();
        nb += int'(busy);
      end
      check("ignored_busy", nb, 0);
      check("ignored_left", fleet_left, ol);
      check("ignored_top", fleet_top, ot);
      return;
    end
    model_frame(v, l, r, t, b, hk);
    frame = 1;
    pulses = 0;
    nb = 0;
    lastidx = -1;
    for (int i = 1; i <= N + 2; i++) begin
      tick();
      if (i == 1) frame = 0;
      if (hit) begin
        pulses++;
        lastidx = int'(hit_idx);
      end
      if (i <= N + 1) nb += int'(busy);
    end
    check("busy_cycles", nb, N + 1);
    check("busy_end", busy, 0);
    check("hit_pulses", pulses, hk >= 0 ? 1 : 0);
    if (hk >= 0) check("hit_idx", lastidx, hk);
    check("count", alive_count, m_count());
    check("left", fleet_left, m_left);
    check("top", fleet_top, m_top);
    check("landed", landed, m_st == ST_LAND);
    check("cleared", cleared, m_st == ST_CLR);
  endtask

  task automatic kill(input int k);
    fire(1, sl(k) + 2, sl(k) + 6, stp(k) + 2, stp(k) + 6);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int l, t, ot, turned;
    do_reset();
    do_start();
    pix(64, 40);
    pix(79, 51);
    pix(80, 40);
    pix(96, 40);
    pix(63, 40);
    pix(64, 52);
    fire(1, 100, 104, 45, 60);
    check("first_hit_idx", hit_idx, 1);
    pix(100, 45);
    pix(101, 46);

    do_reset();
    do_start();
    fire(1, 70, 100, 41, 45);
    check("double_hit_idx", hit_idx, 0);
    check("double_count", alive_count, 23);

    repeat (40) begin
      l = m_left + int'($urandom_range(0, 250));
      t = m_top + int'($urandom_range(0, 90));
      fire($urandom_range(0, 3) != 0, l, l + int'($urandom_range(1, 12)),
           t, t + int'($urandom_range(1, 10)));
      repeat (3)
        pix(m_left + int'($urandom_range(0, 260)) - 4,
            m_top + int'($urandom_range(0, 100)) - 4);
    end

    do_reset();
    do_start();
    kill(7);
    kill(15);
    kill(23);
    turned = 0;
    for (int f = 0; f < 200 && turned == 0; f++) begin
      ot = m_top;
      fire(0, 0, 0, 0, 0);
      if (m_top != ot) begin
        turned = 1;
        check("turn_x", fleet_left, 424);
      end
    end
    check("turned", turned, 1);
    for (int f = 0; f < 2500 && m_st == ST_WAIT; f++) fire(0, 0, 0, 0, 0);
    check("landed_flag", landed, 1);
    fire(0, 0, 0, 0, 0);
    check("landed_hold", landed, 1);
    do_start();
    check("reload_left", fleet_left, 64);

    for (int k = 0; k < N; k++) kill(k);
    check("cleared_flag", cleared, 1);
    fire(0, 0, 0, 0, 0);
    pix(64, 40);

    do_start();
    bv = 1;
    bl = 10'(sl(5) + 2);
    br = 10'(sl(5) + 6);
    bt = 10'(stp(5) + 2);
    bb = 10'(stp(5) + 6);
    frame = 1;
    tick();
    frame = 0;
    repeat (8) tick();
    check("mid_busy", busy, 1);
    check("mid_count", alive_count, 23);
    reset = 1;
    tick();
    check_rst();
    reset = 0;
    model_reload();
    m_st = ST_IDLE;
    fire(0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
